// File: rtl/calc1_sched_pkg.sv
// Shared encodings, port FSM state type and command validation for the calc1 port scheduler.
package calc1_sched_pkg;

   localparam int NUM_PORTS = 4;
   localparam int PORT_W    = 2;

   localparam logic [3:0] CMD_NOP = 4'd0;
   localparam logic [3:0] CMD_ADD = 4'd1;
   localparam logic [3:0] CMD_SUB = 4'd2;
   localparam logic [3:0] CMD_SHL = 4'd5;
   localparam logic [3:0] CMD_SHR = 4'd6;

   localparam logic [1:0] RESP_NONE = 2'd0;
   localparam logic [1:0] RESP_OK   = 2'd1;
   localparam logic [1:0] RESP_ERR  = 2'd2;
   localparam logic [1:0] RESP_BUSY = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_OP2,
      ST_PEND,
      ST_INFL,
      ST_RSP
   } port_state_e;

   function automatic logic is_valid_cmd(input logic [3:0] cmd);
      return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_SHL) || (cmd == CMD_SHR);
   endfunction

endpackage

// File: rtl/calc1_port_scheduler_if.sv
// ALU issue/response bus between the scheduler (master) and the shared ALU back end (slave).
interface calc1_port_scheduler_if #(
   parameter int DATA_W = 32
);
   logic              alu_req_vld;
   logic              alu_req_rdy;
   logic [3:0]        alu_req_cmd;
   logic [DATA_W-1:0] alu_req_op1;
   logic [DATA_W-1:0] alu_req_op2;
   logic [1:0]        alu_req_tag;
   logic              alu_rsp_vld;
   logic [1:0]        alu_rsp_tag;
   logic [1:0]        alu_rsp_resp;
   logic [DATA_W-1:0] alu_rsp_data;

   modport master (
      output alu_req_vld, alu_req_cmd, alu_req_op1, alu_req_op2, alu_req_tag,
      input  alu_req_rdy, alu_rsp_vld, alu_rsp_tag, alu_rsp_resp, alu_rsp_data
   );

   modport slave (
      input  alu_req_vld, alu_req_cmd, alu_req_op1, alu_req_op2, alu_req_tag,
      output alu_req_rdy, alu_rsp_vld, alu_rsp_tag, alu_rsp_resp, alu_rsp_data
   );
endinterface

// File: rtl/calc1_rr_arbiter.sv
// 4-way round-robin arbiter: the port after the last granted one has top priority;
// a registered lock freezes the grant while the issue is stalled.
module calc1_rr_arbiter
   import calc1_sched_pkg::*;
(
   input  logic                 clk,
   input  logic                 srst,
   input  logic [NUM_PORTS-1:0] req,
   input  logic                 lock,
   input  logic                 advance,
   output logic [PORT_W-1:0]    grant_idx,
   output logic                 grant_vld
);

   logic [PORT_W-1:0] last_reg;
   logic              held_reg;
   logic [PORT_W-1:0] held_idx_reg;
   logic [PORT_W-1:0] rr_idx;
   logic [PORT_W-1:0] rr_cand;
   logic              rr_vld;

   // Scan from lowest to highest priority so the highest-priority requester wins last.
   always_comb begin
      rr_idx  = last_reg;
      rr_cand = '0;
      rr_vld  = 1'b0;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         rr_cand = last_reg + PORT_W'(k);
         if (req[rr_cand]) begin
            rr_idx = rr_cand;
            rr_vld = 1'b1;
         end
      end
   end

   assign grant_idx = held_reg ? held_idx_reg : rr_idx;
   assign grant_vld = held_reg | rr_vld;

   always_ff @(posedge clk) begin
      if (srst) begin
         last_reg     <= PORT_W'(NUM_PORTS - 1);
         held_reg     <= 1'b0;
         held_idx_reg <= '0;
      end else begin
         held_reg     <= lock;
         held_idx_reg <= grant_idx;
         if (advance) begin
            last_reg <= grant_idx;
         end
      end
   end

endmodule

// File: rtl/calc1_port_scheduler.sv
// Four-port calc1 request scheduler onto one shared ALU with tagged responses.
// Optional CALC1_SCHED_BUSY_ERR_EN: commands to a PEND/INFL port return a one-cycle busy error.
module calc1_port_scheduler
   import calc1_sched_pkg::*;
#(
   parameter int DATA_W          = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                   c_clk,
   input  logic                   reset,
   input  logic [15:0]            req_cmd_in,
   input  logic [4*DATA_W-1:0]    req_data_in,
   output logic [7:0]             out_resp,
   output logic [4*DATA_W-1:0]    out_data,
   calc1_port_scheduler_if.master alu
);

   logic [NUM_PORTS-1:0] pend_vec;
   logic [NUM_PORTS-1:0] infl_vec;
   logic [3:0]           port_cmd [NUM_PORTS];
   logic [DATA_W-1:0]    port_op1 [NUM_PORTS];
   logic [DATA_W-1:0]    port_op2 [NUM_PORTS];

   logic [PORT_W-1:0] grant_idx;
   logic              grant_vld;
   logic              handshake;
   logic              rsp_accept;
   logic              room;
   logic [2:0]        count_reg;
   logic [2:0]        count_next;

   calc1_rr_arbiter u_arb (
      .clk       (c_clk),
      .srst      (reset),
      .req       (pend_vec),
      .lock      (alu.alu_req_vld & ~alu.alu_req_rdy),
      .advance   (handshake),
      .grant_idx (grant_idx),
      .grant_vld (grant_vld)
   );

   assign room            = (count_reg < 3'(MAX_OUTSTANDING));
   assign alu.alu_req_vld = grant_vld & room;
   assign alu.alu_req_cmd = port_cmd[grant_idx];
   assign alu.alu_req_op1 = port_op1[grant_idx];
   assign alu.alu_req_op2 = port_op2[grant_idx];
   assign alu.alu_req_tag = grant_idx;

   assign handshake  = alu.alu_req_vld & alu.alu_req_rdy;
   // Responses for ports not waiting on the ALU (e.g. stale after reset) are ignored entirely.
   assign rsp_accept = alu.alu_rsp_vld & infl_vec[alu.alu_rsp_tag];

   always_comb begin
      count_next = count_reg;
      case ({handshake, rsp_accept})
         2'b10:   count_next = count_reg + 3'd1;
         2'b01:   count_next = count_reg - 3'd1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge c_clk) begin
      if (reset) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      port_state_e       state_reg, state_next;
      logic [3:0]        cmd_reg, cmd_next;
      logic [DATA_W-1:0] op1_reg, op1_next;
      logic [DATA_W-1:0] op2_reg, op2_next;
      logic [1:0]        out_resp_reg, out_resp_next;
      logic [DATA_W-1:0] out_data_reg, out_data_next;
      logic [3:0]        cmd_in;
      logic [DATA_W-1:0] data_in;
      logic              rsp_hit;
      logic              issue_hit;

      assign cmd_in    = req_cmd_in[4*gi +: 4];
      assign data_in   = req_data_in[DATA_W*gi +: DATA_W];
      assign rsp_hit   = alu.alu_rsp_vld && (alu.alu_rsp_tag == PORT_W'(gi));
      assign issue_hit = handshake && (grant_idx == PORT_W'(gi));

      always_comb begin
         state_next    = state_reg;
         cmd_next      = cmd_reg;
         op1_next      = op1_reg;
         op2_next      = op2_reg;
         out_resp_next = RESP_NONE;
         out_data_next = '0;
         case (state_reg)
            ST_IDLE, ST_RSP: begin
               if (cmd_in != CMD_NOP) begin
                  state_next = ST_OP2;
                  cmd_next   = cmd_in;
                  op1_next   = data_in;
               end else begin
                  state_next = ST_IDLE;
               end
            end
            ST_OP2: begin
               op2_next = data_in;
               if (is_valid_cmd(cmd_reg)) begin
                  state_next = ST_PEND;
               end else begin
                  state_next    = ST_RSP;
                  out_resp_next = RESP_ERR;
               end
            end
            ST_PEND: begin
               if (issue_hit) begin
                  state_next = ST_INFL;
               end
`ifdef CALC1_SCHED_BUSY_ERR_EN
               if (cmd_in != CMD_NOP) begin
                  out_resp_next = RESP_BUSY;
               end
`endif
            end
            ST_INFL: begin
               if (rsp_hit) begin
                  state_next    = ST_RSP;
                  out_resp_next = alu.alu_rsp_resp;
                  out_data_next = alu.alu_rsp_data;
               end
`ifdef CALC1_SCHED_BUSY_ERR_EN
               // The real response takes the output slot; a colliding busy error is dropped.
               else if (cmd_in != CMD_NOP) begin
                  out_resp_next = RESP_BUSY;
               end
`endif
            end
            default: state_next = ST_IDLE;
         endcase
      end

      always_ff @(posedge c_clk) begin
         if (reset) begin
            state_reg    <= ST_IDLE;
            cmd_reg      <= CMD_NOP;
            op1_reg      <= '0;
            op2_reg      <= '0;
            out_resp_reg <= RESP_NONE;
            out_data_reg <= '0;
         end else begin
            state_reg    <= state_next;
            cmd_reg      <= cmd_next;
            op1_reg      <= op1_next;
            op2_reg      <= op2_next;
            out_resp_reg <= out_resp_next;
            out_data_reg <= out_data_next;
         end
      end

      assign pend_vec[gi] = (state_reg == ST_PEND);
      assign infl_vec[gi] = (state_reg == ST_INFL);
      assign port_cmd[gi] = cmd_reg;
      assign port_op1[gi] = op1_reg;
      assign port_op2[gi] = op2_reg;

      assign out_resp[2*gi +: 2]           = out_resp_reg;
      assign out_data[DATA_W*gi +: DATA_W] = out_data_reg;
   end

endmodule

// File: tb/tb_calc1_port_scheduler.sv
// Directed bench for calc1_port_scheduler: a default instance and a MAX_OUTSTANDING=1 instance.
module tb_calc1_port_scheduler;
   import calc1_sched_pkg::*;

   localparam int DW = 32;

   logic          c_clk = 1'b0;
   logic          reset;
   logic [15:0]   req_cmd, req_cmd1;
   logic [4*DW-1:0] req_data, req_data1;
   logic [7:0]    out_resp, out_resp1;
   logic [4*DW-1:0] out_data, out_data1;

   int n_vec  = 0;
   int n_miss = 0;
   int hs_cnt [4] = '{0, 0, 0, 0};
   int order  [4] = '{2, 0, 3, 1};
   int hs_before;

   calc1_port_scheduler_if #(.DATA_W(DW)) alu_bus ();
   calc1_port_scheduler_if #(.DATA_W(DW)) alu1_bus ();

   always #5 c_clk = ~c_clk;

   calc1_port_scheduler #(.DATA_W(DW), .MAX_OUTSTANDING(4)) dut (
      .c_clk       (c_clk),
      .reset       (reset),
      .req_cmd_in  (req_cmd),
      .req_data_in (req_data),
      .out_resp    (out_resp),
      .out_data    (out_data),
      .alu         (alu_bus)
   );

   calc1_port_scheduler #(.DATA_W(DW), .MAX_OUTSTANDING(1)) dut1 (
      .c_clk       (c_clk),
      .reset       (reset),
      .req_cmd_in  (req_cmd1),
      .req_data_in (req_data1),
      .out_resp    (out_resp1),
      .out_data    (out_data1),
      .alu         (alu1_bus)
   );

   always @(posedge c_clk) begin
      if (alu_bus.alu_req_vld && alu_bus.alu_req_rdy) begin
         hs_cnt[alu_bus.alu_req_tag] <= hs_cnt[alu_bus.alu_req_tag] + 1;
      end
   end

   task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge c_clk);
      #1;
   endtask

   task automatic drv(input int p, input logic [3:0] c, input logic [31:0] d);
      req_cmd[4*p +: 4]   = c;
      req_data[DW*p +: DW] = d;
   endtask

   task automatic drv1(input int p, input logic [3:0] c, input logic [31:0] d);
      req_cmd1[4*p +: 4]   = c;
      req_data1[DW*p +: DW] = d;
   endtask

   task automatic rsp(input logic v, input logic [1:0] t, input logic [1:0] r, input logic [31:0] d);
      alu_bus.alu_rsp_vld  = v;
      alu_bus.alu_rsp_tag  = t;
      alu_bus.alu_rsp_resp = r;
      alu_bus.alu_rsp_data = d;
   endtask

   task automatic rsp1(input logic v, input logic [1:0] t, input logic [1:0] r, input logic [31:0] d);
      alu1_bus.alu_rsp_vld  = v;
      alu1_bus.alu_rsp_tag  = t;
      alu1_bus.alu_rsp_resp = r;
      alu1_bus.alu_rsp_data = d;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      req_cmd   = '0;
      req_data  = '0;
      req_cmd1  = '0;
      req_data1 = '0;
      alu_bus.alu_req_rdy  = 1'b0;
      alu1_bus.alu_req_rdy = 1'b0;
      rsp(1'b0, 2'd0, 2'd0, 32'h0);
      rsp1(1'b0, 2'd0, 2'd0, 32'h0);
      repeat (3) tick();
      reset = 1'b0;

      // Reset state
      check_vec("rst_resp", 64'(out_resp), 64'h0);
      check_vec("rst_data", 64'(|out_data), 64'h0);
      check_vec("rst_vld", 64'(alu_bus.alu_req_vld), 64'h0);
      check_vec("rst_vld1", 64'(alu1_bus.alu_req_vld), 64'h0);

      // Port1 add, ALU answers two cycles after the handshake
      alu_bus.alu_req_rdy = 1'b1;
      drv(0, CMD_ADD, 32'h0000_0001);
      tick();
      drv(0, CMD_NOP, 32'h01FF_FFFF);
      tick();
      drv(0, CMD_NOP, 32'h0);
      check_vec("t1_vld", 64'(alu_bus.alu_req_vld), 64'h1);
      check_vec("t1_cmd", 64'(alu_bus.alu_req_cmd), 64'h1);
      check_vec("t1_op1", 64'(alu_bus.alu_req_op1), 64'h1);
      check_vec("t1_op2", 64'(alu_bus.alu_req_op2), 64'h01FF_FFFF);
      check_vec("t1_tag", 64'(alu_bus.alu_req_tag), 64'h0);
      tick();
      check_vec("t1_vld_done", 64'(alu_bus.alu_req_vld), 64'h0);
      tick();
      rsp(1'b1, 2'd0, RESP_OK, 32'h0200_0000);
      check_vec("t1_early", 64'(out_resp), 64'h0);
      tick();
      rsp(1'b0, 2'd0, 2'd0, 32'h0);
      check_vec("t1_resp", 64'(out_resp), 64'h01);
      check_vec("t1_data", 64'(out_data[31:0]), 64'h0200_0000);
      check_vec("t1_other", 64'(|out_data[127:32]), 64'h0);
      tick();
      check_vec("t1_end_resp", 64'(out_resp), 64'h0);
      check_vec("t1_end_data", 64'(out_data[31:0]), 64'h0);

      // All four ports at once: tags 0..3 back to back, then a second round from tag 0
      pulse_reset();
      for (int p = 0; p < 4; p++) drv(p, CMD_SHL, 32'(p + 1));
      tick();
      for (int p = 0; p < 4; p++) drv(p, CMD_NOP, 32'(p + 16));
      tick();
      for (int p = 0; p < 4; p++) drv(p, CMD_NOP, 32'h0);
      for (int i = 0; i < 4; i++) begin
         check_vec("t2_vld", 64'(alu_bus.alu_req_vld), 64'h1);
         check_vec("t2_tag", 64'(alu_bus.alu_req_tag), 64'(i));
         check_vec("t2_op1", 64'(alu_bus.alu_req_op1), 64'(i + 1));
         tick();
      end
      check_vec("t2_idle", 64'(alu_bus.alu_req_vld), 64'h0);
      for (int i = 0; i < 4; i++) begin
         rsp(1'b1, 2'(order[i]), RESP_OK, 32'(32'hA0 + order[i]));
         tick();
         rsp(1'b0, 2'd0, 2'd0, 32'h0);
         check_vec("t2_resp", 64'(out_resp), 64'(8'(1 << (2 * order[i]))));
         check_vec("t2_data", 64'(out_data[DW*order[i] +: DW]), 64'(32'hA0 + order[i]));
      end
      for (int p = 0; p < 4; p++) drv(p, CMD_SHR, 32'h7);
      tick();
      for (int p = 0; p < 4; p++) drv(p, CMD_NOP, 32'h1);
      tick();
      for (int p = 0; p < 4; p++) drv(p, CMD_NOP, 32'h0);
      for (int i = 0; i < 4; i++) begin
         check_vec("t2b_tag", 64'(alu_bus.alu_req_tag), 64'(i));
         check_vec("t2b_cmd", 64'(alu_bus.alu_req_cmd), 64'h6);
         tick();
      end

      // Invalid commands respond with error at T+2; a command in the RSP cycle is captured
      pulse_reset();
      drv(0, 4'd3, 32'h5);
      tick();
      check_vec("t3_vld_op2", 64'(alu_bus.alu_req_vld), 64'h0);
      drv(0, CMD_NOP, 32'h9);
      tick();
      check_vec("t3_resp", 64'(out_resp), 64'h02);
      check_vec("t3_data", 64'(out_data[31:0]), 64'h0);
      check_vec("t3_vld", 64'(alu_bus.alu_req_vld), 64'h0);
      drv(0, 4'd4, 32'h5);
      tick();
      check_vec("t3_gap", 64'(out_resp), 64'h0);
      drv(0, CMD_NOP, 32'h0);
      tick();
      check_vec("t3_resp2", 64'(out_resp), 64'h02);
      check_vec("t3_vld2", 64'(alu_bus.alu_req_vld), 64'h0);
      tick();
      check_vec("t3_end", 64'(out_resp), 64'h0);

      // Stalled issue keeps grant and payload even when a higher-priority port appears
      pulse_reset();
      alu_bus.alu_req_rdy = 1'b0;
      drv(1, CMD_SUB, 32'd100);
      tick();
      drv(1, CMD_NOP, 32'd30);
      drv(0, CMD_ADD, 32'd7);
      tick();
      drv(1, CMD_NOP, 32'h0);
      drv(0, CMD_NOP, 32'd8);
      hs_before = hs_cnt[1];
      for (int i = 0; i < 5; i++) begin
         check_vec("t4_vld", 64'(alu_bus.alu_req_vld), 64'h1);
         check_vec("t4_tag", 64'(alu_bus.alu_req_tag), 64'h1);
         check_vec("t4_cmd", 64'(alu_bus.alu_req_cmd), 64'h2);
         check_vec("t4_op1", 64'(alu_bus.alu_req_op1), 64'd100);
         check_vec("t4_op2", 64'(alu_bus.alu_req_op2), 64'd30);
         if (i == 0) drv(0, CMD_NOP, 32'h0);
         tick();
      end
      alu_bus.alu_req_rdy = 1'b1;
      check_vec("t4_tag_rdy", 64'(alu_bus.alu_req_tag), 64'h1);
      tick();
      check_vec("t4_next_tag", 64'(alu_bus.alu_req_tag), 64'h0);
      check_vec("t4_next_vld", 64'(alu_bus.alu_req_vld), 64'h1);
      check_vec("t4_one_hs", 64'(hs_cnt[1] - hs_before), 64'h1);
      tick();

      // MAX_OUTSTANDING=1: second port waits for the first response; stray tags are dropped
      alu1_bus.alu_req_rdy = 1'b1;
      drv1(1, CMD_ADD, 32'd10);
      drv1(2, CMD_ADD, 32'd20);
      tick();
      drv1(1, CMD_NOP, 32'd1);
      drv1(2, CMD_NOP, 32'd2);
      tick();
      drv1(1, CMD_NOP, 32'h0);
      drv1(2, CMD_NOP, 32'h0);
      check_vec("t5_vld", 64'(alu1_bus.alu_req_vld), 64'h1);
      check_vec("t5_tag", 64'(alu1_bus.alu_req_tag), 64'h1);
      tick();
      check_vec("t5_limit", 64'(alu1_bus.alu_req_vld), 64'h0);
      rsp1(1'b1, 2'd3, RESP_OK, 32'd55);
      tick();
      rsp1(1'b1, 2'd1, RESP_OK, 32'd11);
      check_vec("t5_drop_cnt", 64'(alu1_bus.alu_req_vld), 64'h0);
      check_vec("t5_drop_resp", 64'(out_resp1), 64'h0);
      tick();
      rsp1(1'b0, 2'd0, 2'd0, 32'h0);
      check_vec("t5_resp", 64'(out_resp1), 64'h04);
      check_vec("t5_data", 64'(out_data1[63:32]), 64'd11);
      check_vec("t5_vld3", 64'(alu1_bus.alu_req_vld), 64'h1);
      check_vec("t5_tag3", 64'(alu1_bus.alu_req_tag), 64'h2);
      tick();
      rsp1(1'b1, 2'd2, RESP_OK, 32'd22);
      tick();
      rsp1(1'b0, 2'd0, 2'd0, 32'h0);
      check_vec("t5_resp3", 64'(out_resp1), 64'h10);

      // Reset abandons an in-flight request; the late response is dropped and issue resumes
      drv1(0, CMD_ADD, 32'd3);
      tick();
      drv1(0, CMD_NOP, 32'd4);
      tick();
      drv1(0, CMD_NOP, 32'h0);
      check_vec("t6_vld", 64'(alu1_bus.alu_req_vld), 64'h1);
      tick();
      pulse_reset();
      rsp1(1'b1, 2'd0, RESP_OK, 32'd7);
      tick();
      rsp1(1'b0, 2'd0, 2'd0, 32'h0);
      check_vec("t6_no_resp", 64'(out_resp1), 64'h0);
      drv1(0, CMD_SUB, 32'd9);
      tick();
      drv1(0, CMD_NOP, 32'd2);
      tick();
      drv1(0, CMD_NOP, 32'h0);
      check_vec("t6_reissue", 64'(alu1_bus.alu_req_vld), 64'h1);
      check_vec("t6_tag", 64'(alu1_bus.alu_req_tag), 64'h0);
      check_vec("t6_cmd", 64'(alu1_bus.alu_req_cmd), 64'h2);
      tick();

      // Command to a busy port (INFL): busy error only when the feature is built in
      drv(3, CMD_ADD, 32'd1);
      tick();
      drv(3, CMD_NOP, 32'd2);
      tick();
      drv(3, CMD_NOP, 32'h0);
      check_vec("t7_tag", 64'(alu_bus.alu_req_tag), 64'h3);
      tick();
      drv(3, CMD_ADD, 32'd99);
      tick();
      drv(3, CMD_NOP, 32'h0);
`ifdef CALC1_SCHED_BUSY_ERR_EN
      check_vec("t7_busy", 64'(out_resp), 64'hC0);
`else
      check_vec("t7_busy", 64'(out_resp), 64'h0);
`endif
      check_vec("t7_busy_data", 64'(out_data[127:96]), 64'h0);
      tick();
      check_vec("t7_quiet", 64'(out_resp), 64'h0);
      rsp(1'b1, 2'd3, RESP_OK, 32'd3);
      tick();
      rsp(1'b0, 2'd0, 2'd0, 32'h0);
      check_vec("t7_resp", 64'(out_resp), 64'h40);
      check_vec("t7_data", 64'(out_data[127:96]), 64'd3);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/calc1_port_scheduler.md
Name: calc1_port_scheduler

Overview:
- Sits between the four calc1 requester ports and one shared ALU back end (add/sub/shift).
- Captures each port's two-cycle request (command + operand1, then operand2), filters invalid commands, and arbitrates pending requests round-robin onto a single valid/ready ALU issue interface.
- Routes tagged ALU responses back to the owning port as a one-cycle out_resp/out_data pulse.

Parameters:
- DATA_W, 32: operand/result width.
- MAX_OUTSTANDING, 4: maximum ALU operations in flight (1..4).

Ports:
- c_clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_cmd_in  in  16  port p command in bits [4(p-1):4p-1], p=1..4
- req_data_in  in  4*DATA_W  port p data in slice p-1
- out_resp  out  8  port p response in bits [2(p-1):2p-1]
- out_data  out  4*DATA_W  port p result
- alu_req_vld  out  1  issue valid
- alu_req_rdy  in  1  ALU accepts
- alu_req_cmd  out  4  command (1 add, 2 sub, 5 shl, 6 shr)
- alu_req_op1, alu_req_op2  out  DATA_W  operands
- alu_req_tag  out  2  port index (0..3)
- alu_rsp_vld  in  1  ALU result valid
- alu_rsp_tag  in  2  owning port
- alu_rsp_resp  in  2  1 ok, 2 overflow/underflow
- alu_rsp_data  in  DATA_W  result

Behaviour:
- Reset: all port FSMs to IDLE; out_resp, out_data, alu_req_vld at 0; RR pointer to port 1; in-flight count 0.
- Per-port FSM:
  - IDLE: cmd!=0 → latch cmd and op1, go to OP2. cmd=0 → stay.
  - OP2: latch data as op2; cmd ignored. Cmd in {1,2,5,6} → PEND. Any other value → RSP with resp=2, data=0, no ALU issue.
  - PEND: request the ALU. On vld&rdy handshake for this port → INFL.
  - INFL: on alu_rsp_vld with tag==port → latch resp/data, go to RSP.
  - RSP: drive out_resp/out_data for exactly one cycle. A cmd!=0 in this cycle is captured (→ OP2); otherwise → IDLE.
- out_resp/out_data are 0 in every cycle other than RSP; all are registered outputs.
- Arbitration:
  - Round-robin over PEND ports; highest priority is the port after the last granted port.
  - Pointer advances only on a handshake.
  - alu_req_vld is asserted when any port is in PEND and in-flight count < MAX_OUTSTANDING.
  - Grant and payload are locked while vld&!rdy.
- In-flight count: +1 on handshake, -1 on an accepted alu_rsp_vld. Both in the same cycle leave it unchanged.
- Latency: cmd at T, op2 at T+1, earliest alu_req_vld at T+2. ALU response at cycle R → out_resp at R+1. Invalid command → out_resp at T+2.
- alu_rsp_vld whose tag's port is not in INFL is dropped and does not decrement the count.
- Busy port (OP2/PEND/INFL): req cmd!=0 is ignored (see optional feature).
- Reset mid-operation abandons all requests. ALU responses arriving after reset are dropped.
- Ports may respond in any order; multiple ports may be in RSP in the same cycle.

Optional Feature:
- Macro: CALC1_SCHED_BUSY_ERR_EN.
- Defined: cmd!=0 on a port in PEND or INFL produces a one-cycle out_resp=3, out_data=0 at the next cycle, without disturbing the outstanding request.
  - If this collides with that port's own RSP cycle, the real response wins and the error is dropped.
- Undefined: such commands are silently ignored.

Decomposition:
- Package calc1_sched_pkg: command encodings (CMD_NOP/ADD/SUB/SHL/SHR), response encodings (RESP_NONE/OK/ERR/BUSY), port FSM state typedef, is_valid_cmd function.
- Sub-module calc1_rr_arbiter: 4-way round-robin with lock input. Instantiated once.

Test Plan:
- Port1 cmd=1, op1=0000_0001, op2=01FF_FFFF; ALU model returns sum after 2 cycles → out_resp1=1, out_data1=0200_0000 for one cycle; other ports 0.
- All four ports issue cmd=5 in the same cycle with alu_req_rdy=1 → tags issued 0,1,2,3 on consecutive cycles. A following second round starts at tag 0 (pointer wrapped).
- Port1 cmd=3 then cmd=4 → out_resp1=2, data 0 at T+2 each; alu_req_vld never asserted.
- Port2 pending, alu_req_rdy=0 for 5 cycles → cmd/op/tag stable, exactly one handshake. With MAX_OUTSTANDING=1, port3 issues only after port2's response.
- Port1 in INFL, reset pulsed, then ALU returns tag 0 → no out_resp1. Count is 0 and a new request issues normally.
- With CALC1_SCHED_BUSY_ERR_EN: port4 cmd=1 while in INFL → out_resp4=3 next cycle; original result still delivered with resp=1.
